// File: rtl/cb_mem_resp_if.sv
// Core-bus request/response types shared by cb_mem_resp and its initiators,
// plus an interface bundling one mosi/miso pair with master/slave views.
typedef enum logic [1:0] {
  CB_OKAY   = 2'd0,
  CB_EXOKAY = 2'd1,
  CB_SLVERR = 2'd2,
  CB_DECERR = 2'd3
} cb_resp_e;

typedef struct packed {
  logic        rd_addr_valid;
  logic [31:0] rd_addr;
  logic [2:0]  rd_size;
  logic        rd_ready;
  logic        wr_addr_valid;
  logic [31:0] wr_addr;
  logic [2:0]  wr_size;
  logic        wr_data_valid;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic        wr_resp_ready;
} s_cb_mosi_t;

typedef struct packed {
  logic        rd_addr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  cb_resp_e    rd_resp;
  logic        wr_addr_ready;
  logic        wr_data_ready;
  logic        wr_resp_valid;
  cb_resp_e    wr_resp_error;
} s_cb_miso_t;

interface cb_mem_resp_if;
  s_cb_mosi_t mosi;
  s_cb_miso_t miso;
  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);
endinterface

// File: rtl/cb_mem_resp.sv
// Core-bus word memory responder with independent read and write channels.
// Define CB_MEM_ERR_CHECK_EN to flag out-of-window addresses as CB_SLVERR.
module cb_mem_resp #(
  parameter int unsigned MEM_KB    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t cb_mosi_i,
  output s_cb_miso_t cb_miso_o
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned WORDS     = MEM_KB * 256;
  localparam int unsigned IW        = $clog2(WORDS);
  localparam logic [31:0] WORDS_L   = 32'(WORDS);

  typedef enum logic       {R_IDLE, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [NUM_LANES-1:0][7:0] mem [WORDS];

  logic [31:0]   rd_off, wr_off, rd_word, wr_word;
  logic [IW-1:0] rd_idx, wr_idx;
  logic          rd_err, wr_err;

  assign rd_off  = cb_mosi_i.rd_addr - BASE_ADDR;
  assign wr_off  = cb_mosi_i.wr_addr - BASE_ADDR;
  // In the checked build in-window offsets are already below WORDS, so the
  // modulo only matters for the wrapping build.
  assign rd_word = {2'b00, rd_off[31:2]} % WORDS_L;
  assign wr_word = {2'b00, wr_off[31:2]} % WORDS_L;
  assign rd_idx  = rd_word[IW-1:0];
  assign wr_idx  = wr_word[IW-1:0];

`ifdef CB_MEM_ERR_CHECK_EN
  localparam logic [31:0] BYTES = 32'(MEM_KB * 1024);
  assign rd_err = (rd_off >= BYTES);
  assign wr_err = (wr_off >= BYTES);
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  logic unused;
  assign unused = ^{cb_mosi_i.rd_size, cb_mosi_i.wr_size, rd_off[1:0], wr_off[1:0],
                    rd_word[31:IW], wr_word[31:IW]};

  // Read channel
  r_state_e    r_state_q, r_state_d;
  logic [31:0] rd_data_q, rd_data_d;
  cb_resp_e    rd_resp_q, rd_resp_d;
  logic        rd_addr_ready;

  always_comb begin
    r_state_d     = r_state_q;
    rd_data_d     = rd_data_q;
    rd_resp_d     = rd_resp_q;
    rd_addr_ready = (r_state_q == R_IDLE) || cb_mosi_i.rd_ready;
    if (cb_mosi_i.rd_addr_valid && rd_addr_ready) begin
      r_state_d = R_RESP;
      if (rd_err) begin
        rd_data_d = '0;
        rd_resp_d = CB_SLVERR;
      end else begin
        rd_data_d = mem[rd_idx];
        rd_resp_d = CB_OKAY;
      end
    end else if (r_state_q == R_RESP && cb_mosi_i.rd_ready) begin
      r_state_d = R_IDLE;
    end
  end

  // Write channel; the memory write is gated by rst so a request held
  // during reset cannot land.
  w_state_e      w_state_q, w_state_d;
  logic [IW-1:0] w_idx_q, w_idx_d, mem_widx;
  logic          w_err_q, w_err_d, wr_data_ready, mem_we;
  cb_resp_e      wr_resp_q, wr_resp_d;

  always_comb begin
    w_state_d     = w_state_q;
    w_idx_d       = w_idx_q;
    w_err_d       = w_err_q;
    wr_resp_d     = wr_resp_q;
    wr_data_ready = 1'b0;
    mem_we        = 1'b0;
    mem_widx      = w_idx_q;
    unique case (w_state_q)
      W_IDLE: if (cb_mosi_i.wr_addr_valid) begin
        wr_data_ready = 1'b1;
        w_idx_d       = wr_idx;
        w_err_d       = wr_err;
        if (cb_mosi_i.wr_data_valid) begin
          mem_we    = rst && !wr_err;
          mem_widx  = wr_idx;
          wr_resp_d = wr_err ? CB_SLVERR : CB_OKAY;
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wr_data_ready = 1'b1;
        if (cb_mosi_i.wr_data_valid) begin
          mem_we    = rst && !w_err_q;
          wr_resp_d = w_err_q ? CB_SLVERR : CB_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (cb_mosi_i.wr_resp_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (cb_mosi_i.wr_strobe[b]) mem[mem_widx][b] <= cb_mosi_i.wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rd_data_q <= '0;
      rd_resp_q <= CB_OKAY;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_err_q   <= 1'b0;
      wr_resp_q <= CB_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rd_data_q <= rd_data_d;
      rd_resp_q <= rd_resp_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_err_q   <= w_err_d;
      wr_resp_q <= wr_resp_d;
    end
  end

  always_comb begin
    cb_miso_o               = '0;
    cb_miso_o.rd_addr_ready = rd_addr_ready;
    cb_miso_o.rd_valid      = (r_state_q == R_RESP);
    cb_miso_o.rd_data       = rd_data_q;
    cb_miso_o.rd_resp       = rd_resp_q;
    cb_miso_o.wr_addr_ready = (w_state_q == W_IDLE);
    cb_miso_o.wr_data_ready = wr_data_ready;
    cb_miso_o.wr_resp_valid = (w_state_q == W_RESP);
    cb_miso_o.wr_resp_error = (w_state_q == W_RESP) ? wr_resp_q : CB_OKAY;
  end
endmodule

// File: tb/tb_cb_mem_resp.sv
// Bench for cb_mem_resp: directed protocol checks plus randomized traffic
// scored against a word-array reference model.
module tb_cb_mem_resp;
  localparam int unsigned MEM_KB = 1;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] BYTES  = 32'(MEM_KB * 1024);
  localparam int unsigned NW     = MEM_KB * 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cb_mem_resp_if bus ();

  cb_mem_resp #(.MEM_KB(MEM_KB), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .cb_mosi_i (bus.mosi),
    .cb_miso_o (bus.miso)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  // Reference model: plain word array following the address rules.
  typedef struct { logic [31:0] data; logic [1:0] resp; bit vld; } rd_exp_t;
  rd_exp_t     rd_q[$];
  logic [1:0]  wr_q[$];
  logic [31:0] mdl [NW];
  bit          known [NW];
  logic [31:0] pend_a;

  function automatic void decode(input logic [31:0] a, output bit e, output int i);
    logic [31:0] off;
    off = a - BASE;
`ifdef CB_MEM_ERR_CHECK_EN
    e = (off >= BYTES);
`else
    e = 1'b0;
`endif
    i = int'((off >> 2) % 32'(NW));
  endfunction

  always @(negedge clk) begin : model
    bit e; int i; rd_exp_t re;
    if (!rst) begin
      rd_q.delete();
      wr_q.delete();
    end else begin
      // reads see the array before this cycle's write
      if (bus.mosi.rd_addr_valid && bus.miso.rd_addr_ready) begin
        decode(bus.mosi.rd_addr, e, i);
        re.vld  = e || known[i];
        re.data = e ? 32'h0 : mdl[i];
        re.resp = e ? 2'(CB_SLVERR) : 2'(CB_OKAY);
        rd_q.push_back(re);
      end
      if (bus.mosi.wr_addr_valid && bus.miso.wr_addr_ready) pend_a = bus.mosi.wr_addr;
      if (bus.mosi.wr_data_valid && bus.miso.wr_data_ready) begin
        decode(pend_a, e, i);
        if (!e) begin
          for (int b = 0; b < 4; b++)
            if (bus.mosi.wr_strobe[b]) mdl[i][8*b +: 8] = bus.mosi.wr_data[8*b +: 8];
          if (bus.mosi.wr_strobe == 4'hF) known[i] = 1'b1;
        end
        wr_q.push_back(e ? 2'(CB_SLVERR) : 2'(CB_OKAY));
      end
    end
  end

  always @(negedge clk) begin : monitor
    rd_exp_t re; logic [1:0] we;
    if (rst) begin
      if (bus.miso.rd_valid && bus.mosi.rd_ready) begin
        if (rd_q.size() == 0) fail("rd_unexpected");
        else begin
          re = rd_q.pop_front();
          chk("sb_rd_resp", 32'(bus.miso.rd_resp), 32'(re.resp));
          if (re.vld) chk("sb_rd_data", bus.miso.rd_data, re.data);
        end
      end
      if (bus.miso.wr_resp_valid && bus.mosi.wr_resp_ready) begin
        if (wr_q.size() == 0) fail("wr_unexpected");
        else begin
          we = wr_q.pop_front();
          chk("sb_wr_resp", 32'(bus.miso.wr_resp_error), 32'(we));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ddly, input int rdly);
    int cyc, vcnt; bit ah, dh, a_done, d_done, done;
    bus.mosi.wr_addr = a; bus.mosi.wr_data = d; bus.mosi.wr_strobe = s;
    bus.mosi.wr_addr_valid = 1'b1; bus.mosi.wr_data_valid = (ddly == 0);
    bus.mosi.wr_resp_ready = 1'b0;
    cyc = 0; a_done = 0; d_done = 0;
    while (!d_done && cyc < 40) begin
      @(negedge clk);
      if (a_done) chk("wr_addr_blocked", 32'(bus.miso.wr_addr_ready), 32'd0);
      ah = bus.mosi.wr_addr_valid && bus.miso.wr_addr_ready;
      dh = bus.mosi.wr_data_valid && bus.miso.wr_data_ready;
      tick();
      cyc++;
      if (ah) begin bus.mosi.wr_addr_valid = 1'b0; a_done = 1; end
      if (dh) begin bus.mosi.wr_data_valid = 1'b0; d_done = 1; end
      else if (cyc >= ddly) bus.mosi.wr_data_valid = 1'b1;
    end
    bus.mosi.wr_addr_valid = 1'b0; bus.mosi.wr_data_valid = 1'b0;
    if (!d_done) begin fail("wr_data_hs"); return; end
    bus.mosi.wr_resp_ready = (rdly == 0);
    cyc = 0; vcnt = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) chk("wr_resp_latency", 32'(bus.miso.wr_resp_valid), 32'd1);
      if (bus.miso.wr_resp_valid) begin
        vcnt++;
        chk("wr_addr_blocked", 32'(bus.miso.wr_addr_ready), 32'd0);
      end
      done = bus.miso.wr_resp_valid && bus.mosi.wr_resp_ready;
      tick();
      cyc++;
      if (cyc >= rdly) bus.mosi.wr_resp_ready = 1'b1;
    end
    bus.mosi.wr_resp_ready = 1'b0;
    if (!done) fail("wr_resp_hs");
    else chk("wr_resp_cycles", 32'(vcnt), 32'(rdly + 1));
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int cyc; bit hs;
    bus.mosi.rd_addr = a; bus.mosi.rd_addr_valid = 1'b1; bus.mosi.rd_ready = 1'b1;
    cyc = 0; hs = 0; d = '0; r = '0;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      hs = bus.mosi.rd_addr_valid && bus.miso.rd_addr_ready;
      tick();
      cyc++;
    end
    bus.mosi.rd_addr_valid = 1'b0;
    if (!hs) begin fail("rd_addr_hs"); return; end
    @(negedge clk);
    chk("rd_latency", 32'(bus.miso.rd_valid), 32'd1);
    d = bus.miso.rd_data; r = 2'(bus.miso.rd_resp);
    tick();
    @(negedge clk);
    chk("rd_valid_drop", 32'(bus.miso.rd_valid), 32'd0);
    tick();
    bus.mosi.rd_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 15);
    a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
    if (k == 0) a = BASE + BYTES + 32'($urandom_range(0, 7) * 4);
    else if (k == 1) a = BASE - 32'd4;
    return a;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d, d0, d1;
    logic [1:0]  r;
    bit rh, ah, dh, wrh, w_act, w_dd, drain;

    bus.mosi = '0;
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rd_valid",  32'(bus.miso.rd_valid), 32'd0);
    chk("rst_wr_rvalid", 32'(bus.miso.wr_resp_valid), 32'd0);
    chk("rst_rd_data",   bus.miso.rd_data, 32'd0);
    chk("rst_rd_resp",   32'(bus.miso.rd_resp), 32'(CB_OKAY));
    chk("rst_wr_err",    32'(bus.miso.wr_resp_error), 32'(CB_OKAY));
    chk("rst_rd_aready", 32'(bus.miso.rd_addr_ready), 32'd1);
    chk("rst_wr_aready", 32'(bus.miso.wr_addr_ready), 32'd1);
    chk("rst_wr_dready", 32'(bus.miso.wr_data_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // full-word write then read
    do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(BASE + 32'h10, d, r);
    chk("basic_data", d, 32'hDEADBEEF);
    chk("basic_resp", 32'(r), 32'(CB_OKAY));

    // single-lane strobe; low address bits ignored on the read
    do_write(BASE + 32'h20, 32'h11223344, 4'hF, 0, 0);
    do_write(BASE + 32'h20, 32'h0000AB00, 4'b0010, 0, 0);
    do_read(BASE + 32'h23, d, r);
    chk("strobe_data", d, 32'h1122AB44);

    // data one cycle after address, response held off three cycles
    do_write(BASE + 32'h30, 32'hCAFEF00D, 4'hF, 1, 3);
    do_read(BASE + 32'h30, d, r);
    chk("wdata_path", d, 32'hCAFEF00D);

    // back-to-back reads without a bubble
    do_write(BASE + 32'h0, 32'hA0A0A0A0, 4'hF, 0, 0);
    do_write(BASE + 32'h4, 32'hB1B1B1B1, 4'hF, 0, 0);
    bus.mosi.rd_ready = 1'b1; bus.mosi.rd_addr = BASE; bus.mosi.rd_addr_valid = 1'b1;
    @(negedge clk); chk("b2b_acc0", 32'(bus.miso.rd_addr_ready), 32'd1);
    tick(); bus.mosi.rd_addr = BASE + 32'h4;
    @(negedge clk);
    chk("b2b_v0", 32'(bus.miso.rd_valid), 32'd1);
    chk("b2b_acc1", 32'(bus.miso.rd_addr_ready), 32'd1);
    d0 = bus.miso.rd_data;
    tick(); bus.mosi.rd_addr_valid = 1'b0;
    @(negedge clk); chk("b2b_v1", 32'(bus.miso.rd_valid), 32'd1);
    d1 = bus.miso.rd_data;
    tick();
    @(negedge clk); chk("b2b_idle", 32'(bus.miso.rd_valid), 32'd0);
    chk("b2b_d0", d0, 32'hA0A0A0A0);
    chk("b2b_d1", d1, 32'hB1B1B1B1);
    tick(); bus.mosi.rd_ready = 1'b0;

    // one byte past the window
    do_write(BASE, 32'h11111111, 4'hF, 0, 0);
    do_write(BASE + BYTES, 32'h5A5A5A5A, 4'hF, 0, 0);
    do_read(BASE + BYTES, d, r);
`ifdef CB_MEM_ERR_CHECK_EN
    chk("oob_rd_data", d, 32'h0);
    chk("oob_rd_resp", 32'(r), 32'(CB_SLVERR));
    do_read(BASE, d, r);
    chk("oob_word0", d, 32'h11111111);
`else
    chk("wrap_rd_data", d, 32'h5A5A5A5A);
    chk("wrap_rd_resp", 32'(r), 32'(CB_OKAY));
    do_read(BASE, d, r);
    chk("wrap_word0", d, 32'h5A5A5A5A);
`endif

    // reset while waiting for write data
    do_write(BASE + 32'h40, 32'h01020304, 4'hF, 0, 0);
    bus.mosi.wr_addr = BASE + 32'h40; bus.mosi.wr_data = 32'hFFFFFFFF;
    bus.mosi.wr_strobe = 4'hF; bus.mosi.wr_addr_valid = 1'b1;
    @(negedge clk); chk("rst_mid_acc", 32'(bus.miso.wr_addr_ready), 32'd1);
    tick(); bus.mosi.wr_addr_valid = 1'b0;
    @(negedge clk); chk("rst_mid_wdata", 32'(bus.miso.wr_data_ready), 32'd1);
    rst = 1'b0; #1;
    chk("rst_mid_rvalid", 32'(bus.miso.wr_resp_valid), 32'd0);
    chk("rst_mid_aready", 32'(bus.miso.wr_addr_ready), 32'd1);
    chk("rst_mid_rdata",  bus.miso.rd_data, 32'd0);
    bus.mosi.wr_data_valid = 1'b1;
    tick(); tick();
    bus.mosi.wr_data_valid = 1'b0;
    chk("rst_mid_dready", 32'(bus.miso.wr_data_ready), 32'd0);
    rst = 1'b1;
    tick();
    do_read(BASE + 32'h40, d, r);
    chk("rst_mid_word", d, 32'h01020304);

    // randomized concurrent traffic on both channels, then drain
    w_act = 0; w_dd = 0;
    for (int c = 0; c < 3060; c++) begin
      drain = (c >= 3000);
      @(negedge clk);
      rh  = bus.mosi.rd_addr_valid && bus.miso.rd_addr_ready;
      ah  = bus.mosi.wr_addr_valid && bus.miso.wr_addr_ready;
      dh  = bus.mosi.wr_data_valid && bus.miso.wr_data_ready;
      wrh = bus.miso.wr_resp_valid && bus.mosi.wr_resp_ready;
      tick();
      if (rh) bus.mosi.rd_addr_valid = 1'b0;
      if (!drain && !bus.mosi.rd_addr_valid && $urandom_range(0, 2) == 0) begin
        bus.mosi.rd_addr = rnd_addr();
        bus.mosi.rd_addr_valid = 1'b1;
      end
      bus.mosi.rd_ready = drain || ($urandom_range(0, 3) != 0);
      if (ah) bus.mosi.wr_addr_valid = 1'b0;
      if (dh) begin bus.mosi.wr_data_valid = 1'b0; w_dd = 1; end
      if (wrh) w_act = 0;
      if (!w_act) begin
        if (!drain && $urandom_range(0, 2) == 0) begin
          w_act = 1; w_dd = 0;
          bus.mosi.wr_addr       = rnd_addr();
          bus.mosi.wr_data       = $urandom();
          bus.mosi.wr_strobe     = 4'($urandom_range(0, 15));
          bus.mosi.wr_addr_valid = 1'b1;
          bus.mosi.wr_data_valid = 1'($urandom_range(0, 1));
        end
      end else if (!w_dd && !bus.mosi.wr_data_valid && (drain || $urandom_range(0, 1) == 1)) begin
        bus.mosi.wr_data_valid = 1'b1;
      end
      bus.mosi.wr_resp_ready = drain || ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    chk("sb_rd_drained", 32'(rd_q.size()), 32'd0);
    chk("sb_wr_drained", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cb_mem_resp.md
CB_MEM_RESP -- requirements
Module: cb_mem_resp

Interface
REQ-001 SHALL have parameter MEM_KB, default 16, memory size in KiB (word count = MEM_KB*256).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first byte address served; word-aligned.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cb_mosi_i  input  s_cb_mosi_t  core-bus requests from the initiator (address, write data/strobe, ready signals).
REQ-006 SHALL have port cb_miso_o  output  s_cb_miso_t  core-bus responses (address/data readies, read data/resp, write response).

Function
REQ-007 SHALL compute word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored; rd_size/wr_size ignored, wr_strobe alone selects written bytes.
REQ-008 SHALL run read FSM R_IDLE/R_RESP; rd_addr_ready = 1 in R_IDLE, or in R_RESP when rd_ready = 1 that cycle.
REQ-009 SHALL, on rd_addr_valid & rd_addr_ready, register read data and enter R_RESP; rd_valid rises the next cycle (1-cycle latency).
REQ-010 SHALL hold rd_valid, rd_data, rd_resp stable until rd_valid & rd_ready; then return to R_IDLE unless a new address is accepted in that cycle (back-to-back: stay in R_RESP, new data the next cycle).
REQ-011 SHALL run write FSM W_IDLE/W_DATA/W_RESP; wr_addr_ready = 1 only in W_IDLE.
REQ-012 SHALL, on wr_addr handshake, latch the index; if wr_data_valid is also 1 that cycle, write immediately and go to W_RESP, else go to W_DATA.
REQ-013 SHALL drive wr_data_ready = 1 in W_DATA and in W_IDLE when wr_addr_valid = 1; a wr_data_valid in W_IDLE without wr_addr_valid SHALL NOT be accepted.
REQ-014 SHALL, on the data handshake, update byte lane i (i = 0..3) only when wr_strobe[i] = 1, and enter W_RESP; wr_resp_valid rises the next cycle.
REQ-015 SHALL hold wr_resp_valid and wr_resp_error until wr_resp_ready = 1, then return to W_IDLE.
REQ-016 SHALL, when a read and a write to the same word take effect in the same cycle, return the pre-write contents (read-before-write).
REQ-017 SHALL process read and write channels independently; neither blocks the other.
REQ-018 SHALL drive rd_resp and wr_resp_error to CB_OKAY except as in REQ-023.
REQ-019 SHALL drive all unused miso fields to 0.

Reset
REQ-020 SHALL, while rst = 0, force R_IDLE, W_IDLE, rd_valid = 0, wr_resp_valid = 0, rd_data = 0, rd_resp = wr_resp_error = CB_OKAY; readies reflect idle states (rd_addr_ready = 1, wr_addr_ready = 1).
REQ-021 SHALL NOT reset memory contents; reads before any write return undefined data.
REQ-022 SHALL discard an in-flight read or write on reset mid-operation; a write whose data handshake had not completed SHALL leave memory unchanged.

Configuration
REQ-023 SHALL, with CB_MEM_ERR_CHECK_EN defined, treat addresses outside [BASE_ADDR, BASE_ADDR + MEM_KB*1024) as errors: reads return rd_data = 0 and rd_resp = CB_SLVERR; writes skip the memory update and return wr_resp_error = CB_SLVERR; handshake timing unchanged.
REQ-024 SHALL, without CB_MEM_ERR_CHECK_EN, wrap the word index modulo word count and always respond CB_OKAY.

Verification
REQ-025 SHALL cover: write 0xDEADBEEF strobe 4'b1111 to BASE_ADDR+0x10, then read it -> rd_valid one cycle after rd_addr handshake, rd_data 0xDEADBEEF, CB_OKAY.
REQ-026 SHALL cover: write 0x0000AB00 strobe 4'b0010 over 0x11223344 -> read returns 0x1122AB44.
REQ-027 SHALL cover: address at cycle N, data at N+1 (W_DATA path), wr_resp_ready low 3 cycles -> wr_resp_valid stable 4 cycles, wr_addr_ready = 0 until the resp handshake.
REQ-028 SHALL cover: back-to-back reads of 0x0, 0x4 with rd_ready = 1 -> rd_valid high two consecutive cycles, data in order, no bubble.
REQ-029 SHALL cover: with CB_MEM_ERR_CHECK_EN, read/write at BASE_ADDR + MEM_KB*1024 -> CB_SLVERR, rd_data 0, word at 0x0 unchanged; without the macro, the same write lands at word 0.
REQ-030 SHALL cover: rst asserted while in W_DATA -> W_IDLE, wr_resp_valid = 0, target word unchanged after release.
